sk6805_rx_decoder: RTL and testbench

//  Receiver for the SK6805 single-wire LED protocol. Samples a serial LED line, measures

---
 rtl/sk6805_pkg.sv | 31 +++
 rtl/sk6805_rx_decoder_if.sv | 29 ++
 rtl/sk6805_pulse_meter.sv | 62 ++++++
 rtl/sk6805_rx_decoder.sv | 167 ++++++++++++++++
 tb/tb_sk6805_rx_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sk6805_pkg.sv
// Shared definitions for the SK6805 receive path: FSM states, error codes,
// GRB field layout and the nominal 10 MHz protocol timing.
package sk6805_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } rx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_GLITCH  = 2'd1;
  localparam logic [1:0] ERR_STUCK   = 2'd2;
  localparam logic [1:0] ERR_PARTIAL = 2'd3;

  localparam int GRB_BITS = 24;
  localparam int G_LSB    = 16;
  localparam int R_LSB    = 8;
  localparam int B_LSB    = 0;

  localparam int T0H_CYC   = 3;
  localparam int T1H_CYC   = 6;
  localparam int T_BIT_CYC = 12;
  localparam int T_GAP_CYC = 500;

  function automatic logic [7:0] grb_field(input logic [23:0] word, input int lsb);
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/sk6805_rx_decoder_if.sv
// Decoder bus: the serial line in, decoded pixel / frame / error reports out.
interface sk6805_rx_decoder_if #(
  parameter int PIXEL_IDX_W = 4
);

  logic                   LED_IO;
  logic [7:0]             R_Out;
  logic [7:0]             G_Out;
  logic [7:0]             B_Out;
  logic [PIXEL_IDX_W-1:0] Pixel_Idx;
  logic                   Pixel_Valid;
  logic                   Frame_Done;
  logic [PIXEL_IDX_W-1:0] Frame_Pixels;
  logic                   Err;
  logic [1:0]             Err_Code;

  modport master (
    input  LED_IO,
    output R_Out, G_Out, B_Out, Pixel_Idx, Pixel_Valid,
    output Frame_Done, Frame_Pixels, Err, Err_Code
  );

  modport slave (
    output LED_IO,
    input  R_Out, G_Out, B_Out, Pixel_Idx, Pixel_Valid,
    input  Frame_Done, Frame_Pixels, Err, Err_Code
  );

endinterface

// File: rtl/sk6805_pulse_meter.sv
// Synchronizes the LED line, flags its edges and measures consecutive
// high/low run lengths with counters that saturate at CNT_MAX.
module sk6805_pulse_meter #(
  parameter int CNT_W   = 9,
  parameter int CNT_MAX = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] high_run_o,
  output logic [CNT_W-1:0] low_run_o,
  output logic [CNT_W-1:0] high_width_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(CNT_MAX);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;

  // Run lengths include the current synchronized sample.
  always_comb begin
    sync1_d = led_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    hcnt_d  = '0;
    lcnt_d  = '0;
    if (sync2_q) begin
      hcnt_d = (hcnt_q == MAX_C) ? hcnt_q : hcnt_q + 1'b1;
    end else begin
      lcnt_d = (lcnt_q == MAX_C) ? lcnt_q : lcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign rise_o       = sync2_q & ~prev_q;
  assign fall_o       = ~sync2_q & prev_q;
  assign high_run_o   = hcnt_d;
  assign low_run_o    = lcnt_d;
  // On a falling edge the previous run is the width of the finished pulse.
  assign high_width_o = hcnt_q;

endmodule

// File: rtl/sk6805_rx_decoder.sv
// SK6805 line receiver: decodes high-pulse widths into 24-bit GRB pixels and
// reports pixels, frame ends and protocol errors through registered pulses.
module sk6805_rx_decoder #(
  parameter int BIT_THRESH  = 5,
  parameter int MIN_HIGH    = 2,
  parameter int MAX_HIGH    = 10,
  parameter int RESET_LOW   = 500,
  parameter int PIXEL_IDX_W = 4
) (
  input logic                clk_10MHz,
  input logic                Rst,
  sk6805_rx_decoder_if.master bus
);
  import sk6805_pkg::*;

  localparam int               CNT_W    = $clog2(RESET_LOW + 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] STUCK_C  = CNT_W'(MAX_HIGH + 1);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(RESET_LOW);
  localparam logic [4:0]       LAST_BIT = 5'(GRB_BITS - 1);

  logic             rise, fall;
  logic [CNT_W-1:0] high_run, low_run, high_width;

  sk6805_pulse_meter #(.CNT_W(CNT_W), .CNT_MAX(RESET_LOW)) u_meter (
    .clk          (clk_10MHz),
    .rst          (Rst),
    .led_i        (bus.LED_IO),
    .rise_o       (rise),
    .fall_o       (fall),
    .high_run_o   (high_run),
    .low_run_o    (low_run),
    .high_width_o (high_width)
  );

  rx_state_e              state_q, state_d;
  logic [23:0]            sr_q, sr_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [PIXEL_IDX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]             r_q, r_d, g_q, g_d, b_q, b_d;
  logic [PIXEL_IDX_W-1:0] idx_q, idx_d, fp_q, fp_d;
  logic                   pv_q, pv_d, fd_q, fd_d, err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic [23:0]            full_word;

  assign full_word = {sr_q[22:0], (high_width >= THRESH_C)};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    idx_d     = idx_q;
    fp_d      = fp_q;
    code_d    = code_q;
    pv_d      = 1'b0;
    fd_d      = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        if (low_run >= GAP_C) begin
          state_d   = ST_IDLE;
          pix_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall) begin
          if (high_width < MIN_C) begin
            err_d     = 1'b1;
            code_d    = ERR_GLITCH;
            sr_d      = '0;
            bit_cnt_d = '0;
            state_d   = ST_SYNC;
          end else begin
            sr_d    = full_word;
            state_d = ST_LOW;
            if (bit_cnt_q == LAST_BIT) begin
              g_d       = grb_field(full_word, G_LSB);
              r_d       = grb_field(full_word, R_LSB);
              b_d       = grb_field(full_word, B_LSB);
              idx_d     = pix_cnt_q;
              pv_d      = 1'b1;
              bit_cnt_d = '0;
              if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (high_run == STUCK_C) begin
          err_d     = 1'b1;
          code_d    = ERR_STUCK;
          sr_d      = '0;
          bit_cnt_d = '0;
          state_d   = ST_SYNC;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (low_run >= GAP_C) begin
          // A reset gap closes the frame; leftover bits are reported and dropped.
          fd_d = 1'b1;
          fp_d = pix_cnt_q;
          if (bit_cnt_q != '0) begin
            err_d  = 1'b1;
            code_d = ERR_PARTIAL;
          end
          pix_cnt_d = '0;
          bit_cnt_d = '0;
          sr_d      = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk_10MHz or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_SYNC;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      fp_q      <= '0;
      code_q    <= ERR_NONE;
      pv_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      fp_q      <= fp_d;
      code_q    <= code_d;
      pv_q      <= pv_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

  assign bus.R_Out        = r_q;
  assign bus.G_Out        = g_q;
  assign bus.B_Out        = b_q;
  assign bus.Pixel_Idx    = idx_q;
  assign bus.Pixel_Valid  = pv_q;
  assign bus.Frame_Done   = fd_q;
  assign bus.Frame_Pixels = fp_q;
  assign bus.Err          = err_q;
  assign bus.Err_Code     = code_q;

endmodule

// File: tb/tb_sk6805_rx_decoder.sv
// Scoreboard bench for sk6805_rx_decoder: stimulus queues expected reports,
// a monitor pops and compares them whenever the decoder pulses an output.
module tb_sk6805_rx_decoder;
  import sk6805_pkg::*;

  localparam int IDX_W = 4;
  localparam int GAP   = T_GAP_CYC + 20;

  typedef enum int {EV_PIXEL, EV_FRAME, EV_FRAME_ERR, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int r; int g; int b; int idx; int fp; int code; int lat_ref;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  sk6805_rx_decoder_if #(.PIXEL_IDX_W(IDX_W)) bus();

  sk6805_rx_decoder #(
    .BIT_THRESH(5), .MIN_HIGH(2), .MAX_HIGH(10), .RESET_LOW(T_GAP_CYC), .PIXEL_IDX_W(IDX_W)
  ) dut (
    .clk_10MHz (clk),
    .Rst       (rst),
    .bus       (bus.master)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    bus.LED_IO = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n, input int h0, input int h1);
    int h;
    for (int i = 23; i > 23 - n; i--) begin
      h = w[i] ? h1 : h0;
      applyStimulus(1'b1, h);
      applyStimulus(1'b0, T_BIT_CYC - h);
    end
  endtask

  function automatic void push_exp(input ev_kind_e kind, input int g, input int r, input int b,
                                   input int idx, input int fp, input int code, input int lat_ref);
    exp_t e;
    e.kind = kind; e.g = g; e.r = r; e.b = b;
    e.idx = idx; e.fp = fp; e.code = code; e.lat_ref = lat_ref;
    exp_q.push_back(e);
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_r"},    int'(bus.R_Out), 0);
    checkOutput({tag, "_g"},    int'(bus.G_Out), 0);
    checkOutput({tag, "_b"},    int'(bus.B_Out), 0);
    checkOutput({tag, "_idx"},  int'(bus.Pixel_Idx), 0);
    checkOutput({tag, "_pv"},   int'(bus.Pixel_Valid), 0);
    checkOutput({tag, "_fd"},   int'(bus.Frame_Done), 0);
    checkOutput({tag, "_fp"},   int'(bus.Frame_Pixels), 0);
    checkOutput({tag, "_err"},  int'(bus.Err), 0);
    checkOutput({tag, "_code"}, int'(bus.Err_Code), 0);
  endtask

  // Monitor: every reported event must match the oldest queued expectation.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst && (bus.Pixel_Valid || bus.Frame_Done || bus.Err)) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", {29'd0, bus.Pixel_Valid, bus.Frame_Done, bus.Err}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pixel_valid", int'(bus.Pixel_Valid), int'(e.kind == EV_PIXEL));
          checkOutput("frame_done", int'(bus.Frame_Done),
                      int'(e.kind == EV_FRAME || e.kind == EV_FRAME_ERR));
          checkOutput("err", int'(bus.Err), int'(e.kind == EV_ERR || e.kind == EV_FRAME_ERR));
          if (e.kind == EV_PIXEL) begin
            checkOutput("r_out", int'(bus.R_Out), e.r);
            checkOutput("g_out", int'(bus.G_Out), e.g);
            checkOutput("b_out", int'(bus.B_Out), e.b);
            checkOutput("pixel_idx", int'(bus.Pixel_Idx), e.idx);
          end
          if (e.kind == EV_FRAME || e.kind == EV_FRAME_ERR)
            checkOutput("frame_pixels", int'(bus.Frame_Pixels), e.fp);
          if (e.kind == EV_ERR || e.kind == EV_FRAME_ERR)
            checkOutput("err_code", int'(bus.Err_Code), e.code);
          if (e.lat_ref >= 0) begin
            lat = cyc - e.lat_ref;
            checks++;
            if (lat < 13 || lat > 14) begin
              errors++;
              $display("[TB] FAIL err_latency: got %0d cycles, expected 13..14", lat);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.LED_IO = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    $display("[TB] single pixel and frame");
    applyStimulus(1'b0, 600);
    push_exp(EV_PIXEL, 'h12, 'hA5, 'h3C, 0, 0, 0, -1);
    send_bits(24'h12A53C, 24, T0H_CYC, T1H_CYC);
    push_exp(EV_FRAME, 0, 0, 0, 0, 1, 0, -1);
    applyStimulus(1'b0, GAP);

    $display("[TB] three pixels, width boundaries");
    push_exp(EV_PIXEL, 'h01, 'h80, 'hFF, 0, 0, 0, -1);
    send_bits(24'h0180FF, 24, T0H_CYC, T1H_CYC);
    push_exp(EV_PIXEL, 'hF0, 'h0F, 'h5A, 1, 0, 0, -1);
    send_bits(24'hF00F5A, 24, 4, 5);
    push_exp(EV_PIXEL, 'h81, 'h7E, 'hC3, 2, 0, 0, -1);
    send_bits(24'h817EC3, 24, 2, 10);
    push_exp(EV_FRAME, 0, 0, 0, 0, 3, 0, -1);
    applyStimulus(1'b0, GAP);

    $display("[TB] glitch then resync");
    send_bits(24'hFFFFFF, 8, T0H_CYC, T1H_CYC);
    push_exp(EV_ERR, 0, 0, 0, 0, 0, ERR_GLITCH, -1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 11);
    send_bits(24'hFFFFFF, 24, T0H_CYC, T1H_CYC);
    applyStimulus(1'b0, GAP);
    push_exp(EV_PIXEL, 'h5A, 'hC3, 'h01, 0, 0, 0, -1);
    send_bits(24'h5AC301, 24, T0H_CYC, T1H_CYC);
    push_exp(EV_FRAME, 0, 0, 0, 0, 1, 0, -1);
    applyStimulus(1'b0, GAP);

    $display("[TB] stuck high");
    send_bits(24'hAAAAAA, 5, T0H_CYC, T1H_CYC);
    push_exp(EV_ERR, 0, 0, 0, 0, 0, ERR_STUCK, cyc);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, GAP);
    checkOutput("err_code_hold_stuck", int'(bus.Err_Code), ERR_STUCK);

    $display("[TB] partial pixel at frame end");
    send_bits(24'h123456, 12, T0H_CYC, T1H_CYC);
    push_exp(EV_FRAME_ERR, 0, 0, 0, 0, 0, ERR_PARTIAL, -1);
    applyStimulus(1'b0, GAP);
    checkOutput("err_code_hold_partial", int'(bus.Err_Code), ERR_PARTIAL);

    $display("[TB] reset mid-pixel");
    send_bits(24'h0F0F0F, 10, T0H_CYC, T1H_CYC);
    applyStimulus(1'b1, 2);
    rst = 1'b1;
    bus.LED_IO = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    send_bits(24'hFFFFFF, 24, T0H_CYC, T1H_CYC);
    applyStimulus(1'b0, GAP);
    push_exp(EV_PIXEL, 'h33, 'h44, 'h55, 0, 0, 0, -1);
    send_bits(24'h334455, 24, T0H_CYC, T1H_CYC);
    push_exp(EV_FRAME, 0, 0, 0, 0, 1, 0, -1);
    applyStimulus(1'b0, GAP);

    repeat (20) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
